// File: rtl/lsu_pkg.sv
// lsu_pkg: shared request-type codes, FSM state encoding and lane/legality helpers for the LSU.
package lsu_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic type_legal(input logic [2:0] t);
    return t <= DM_BYTE_U;
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_HALF_U);
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    return is_half(t) ? off[0] : (t == DM_WORD) ? (off != 2'b00) : 1'b0;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] off);
    return (t == DM_WORD) ? 4'b1111 : is_half(t) ? (4'b0011 << off) : (4'b0001 << off);
  endfunction

  function automatic logic [31:0] lane_rep(input logic [2:0] t, input logic [31:0] d);
    return (t == DM_WORD) ? d : is_half(t) ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: picks the addressed byte/half/word out of a 32-bit bus word and sign/zero-extends it.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  type_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  // Extend the low lane of the shifted word according to the access type.
  always_comb
    data_o = (type_i == DM_WORD)   ? sh :
             (type_i == DM_HALF)   ? {{16{sh[15]}}, sh[15:0]} :
             (type_i == DM_HALF_U) ? {16'b0, sh[15:0]} :
             (type_i == DM_BYTE)   ? {{24{sh[7]}}, sh[7:0]} :
             (type_i == DM_BYTE_U) ? {24'b0, sh[7:0]} : 32'b0;

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit bus initiator; one request at a time, byte-lane stores, extended loads.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned half/word accesses are
// split into single-byte beats instead of completing with rsp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    type_q, type_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          split_q, split_d;
  logic [1:0]    beat_q, beat_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [AW-1:0] beat_addr;
  logic [1:0]    lane;
  logic [7:0]    beat_byte;
  logic [31:0]   merged;
  logic          last;
  logic          issue;
  logic [31:0]   ext_data;

  // Non-split accesses keep beat_q at 0, so beat_addr is simply the request address.
  assign beat_addr = addr_q + AW'(beat_q);
  assign lane      = beat_addr[1:0];
  assign beat_byte = mem_rdata[{lane, 3'b000} +: 8];
  assign merged    = merge_q | ({24'b0, beat_byte} << {beat_q, 3'b000});
  assign last      = !split_q || (beat_q == ((type_q == DM_WORD) ? 2'd3 : 2'd1));
  assign issue     = (state_q == S_ISSUE);

  // Split loads are assembled little-endian in merged, so extension then starts at lane 0.
  lsu_extend u_ext (
    .rdata_i (split_q ? merged : mem_rdata),
    .off_i   (split_q ? 2'b00 : addr_q[1:0]),
    .type_i  (type_q),
    .data_o  (ext_data)
  );

  // Bus and response outputs are decoded from state so they read 0 outside their phase.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rsp_valid ? rdata_q : 32'b0;
    rsp_err   = rsp_valid & err_q;
    mem_req   = issue;
    mem_we    = issue & we_q;
    mem_addr  = issue ? {beat_addr[AW-1:2], 2'b00} : '0;
    mem_be    = !issue ? 4'b0 : split_q ? (4'b0001 << lane) : byte_en(type_q, addr_q[1:0]);
    mem_wdata = !issue ? 32'b0 : split_q ? {4{wdata_q[{beat_q, 3'b000} +: 8]}} : lane_rep(type_q, wdata_q);
  end

  // Next-state: accept and classify in IDLE, hold the bus until grant, collect beats in WAIT.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    split_d = split_q;
    beat_d  = beat_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d    = req_we;
        type_d  = req_type;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        err_d   = !type_legal(req_type) || (misaligned(req_type, req_addr[1:0]) && !SPLIT);
        split_d = type_legal(req_type) && misaligned(req_type, req_addr[1:0]) && SPLIT;
        beat_d  = 2'd0;
        merge_d = 32'b0;
        rdata_d = 32'b0;
        state_d = err_d ? S_RESP : S_ISSUE;
      end
      S_ISSUE: if (mem_gnt) state_d = S_WAIT;
      S_WAIT: if (mem_rvalid) begin
        merge_d = merged;
        if (last) begin
          rdata_d = we_q ? 32'b0 : ext_data;
          state_d = S_RESP;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset aborts any transaction in flight without a response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      type_q  <= DM_WORD;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      beat_q  <= 2'd0;
      merge_q <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      split_q <= split_d;
      beat_q  <= beat_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
